// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter: captures request pulses into a pending register
// and issues one registered one-hot grant at a time, held until done or watchdog timeout.
module rr_arbiter_8 #(
   parameter int TIMEOUT = 15,
   parameter int CW      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic       grant_valid,
   output logic       timeout,
   output logic [7:0] pending
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_t;

   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

   arbState_t     state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    grant_q, grant_d;
   logic [7:0]    pending_q, pending_d;
   logic          timeout_q, timeout_d;

   logic [7:0]    clrMask;
   logic [2:0]    winIdx;
   logic          winFound;
   logic [2:0]    candIdx;

   // Search upward from ptr+1 with wrap, so the last winner has lowest priority.
   always_comb begin
      winIdx   = 3'd0;
      winFound = 1'b0;
      candIdx  = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         candIdx = 3'(int'(ptr_q) + k);
         if (!winFound && pending_q[candIdx]) begin
            winFound = 1'b1;
            winIdx   = candIdx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      timeout_d = 1'b0;
      clrMask   = 8'h00;
      unique case (state_q)
         IDLE: begin
            if (winFound) begin
               grant_d = 8'h01 << winIdx;
               clrMask = 8'h01 << winIdx;
               ptr_d   = winIdx;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (done) begin
               grant_d = 8'h00;
               state_d = IDLE;
            end else if (cnt_q == LAST_COUNT) begin
               grant_d   = 8'h00;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            grant_d = 8'h00;
            state_d = IDLE;
         end
      endcase
      // A request arriving on the bit being cleared re-queues it.
      pending_d = (pending_q & ~clrMask) | req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd7;
         cnt_q     <= '0;
         grant_q   <= 8'h00;
         pending_q <= 8'h00;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         pending_q <= pending_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign timeout     = timeout_q;
   assign pending     = pending_q;

endmodule
